// File: rtl/data_mem_responder.sv
// 256-byte big-endian data memory slave for the MEM stage: one request at a time, registered read data.
// Define DMEM_WAIT_STATE_EN to insert a single WAIT state between ACCESS and RESP.
module data_mem_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        E,
  input  logic        RW,
  input  logic        SIZE,
  input  logic [7:0]  A,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [7:0]  a_q;
  logic        rw_q;
  logic        size_q;
  logic [31:0] di_q;
  logic        err_q;
  logic        misaligned;
  logic        do_access;
  logic [7:0]  addr0;
  logic [7:0]  addr1;
  logic [7:0]  addr2;
  logic [7:0]  addr3;
  logic [7:0]  mem [0:255];

  // Word lanes are only used when aligned, so OR-ing the low bits never wraps past 255.
  assign misaligned = size_q && (a_q[1:0] != 2'b00);
  assign addr0      = a_q;
  assign addr1      = {a_q[7:2], 2'b01};
  assign addr2      = {a_q[7:2], 2'b10};
  assign addr3      = {a_q[7:2], 2'b11};
  assign do_access  = (state == ACCESS) && !misaligned;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (E) state_next = ACCESS;
`ifdef DMEM_WAIT_STATE_EN
      ACCESS: state_next = WAIT;
`else
      ACCESS: state_next = RESP;
`endif
      WAIT:   state_next = RESP;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request fields are captured only on acceptance, so inputs are don't-care while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= 8'h00;
      rw_q   <= 1'b0;
      size_q <= 1'b0;
      di_q   <= 32'h0;
    end else if ((state == IDLE) && E) begin
      a_q    <= A;
      rw_q   <= RW;
      size_q <= SIZE;
      di_q   <= DI;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == ACCESS) begin
      err_q <= misaligned;
    end
  end

  // DO only moves on a completed, aligned read; writes and faulted accesses leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DO <= 32'h0;
    end else if (do_access && !rw_q) begin
      if (size_q) begin
        DO <= {mem[addr0], mem[addr1], mem[addr2], mem[addr3]};
      end else begin
        DO <= {24'h0, mem[addr0]};
      end
    end
  end

  // Storage has no reset; an aborted request never reaches ACCESS because reset parks the FSM in IDLE.
  always_ff @(posedge clk) begin
    if (do_access && rw_q) begin
      if (size_q) begin
        mem[addr0] <= di_q[31:24];
        mem[addr1] <= di_q[23:16];
        mem[addr2] <= di_q[15:8];
        mem[addr3] <= di_q[7:0];
      end else begin
        mem[addr0] <= di_q[7:0];
      end
    end
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);
  assign err   = (state == RESP) && err_q;

endmodule
